// File: rtl/line_draw_sequencer_pkg.sv
// Shared definitions for the line draw sequencer: FSM state encoding and
// width helpers used by the interface, the arbiter and the sequencer.
package line_draw_sequencer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_WAIT   = 2'd2,
    ST_STREAM = 2'd3
  } state_e;

  // Index width that stays at least one bit wide for single-entry ranges.
  function automatic int unsigned idx_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/line_draw_sequencer_if.sv
// Requester, bresenham-core and pixel-port signals of the line draw sequencer.
// slave = sequencer side, master = environment side.
interface line_draw_sequencer_if
  import line_draw_sequencer_pkg::*;
#(
  parameter int unsigned P_NUM_REQ         = 2,
  parameter int unsigned P_MAX_LINE_LENGTH = 31,
  parameter int unsigned P_X_COORD_W       = 9,
  parameter int unsigned P_Y_COORD_W       = 9
);
  localparam int unsigned SRC_W = idx_width(P_NUM_REQ);
  localparam int unsigned REQ_W = 2 * P_X_COORD_W + 2 * P_Y_COORD_W;

  logic [P_NUM_REQ-1:0]                       i_req_valid;
  logic [P_NUM_REQ*REQ_W-1:0]                 i_req_coords;
  logic [P_NUM_REQ-1:0]                       o_req_ready;
  logic [P_X_COORD_W-1:0]                     o_bres_x0;
  logic [P_X_COORD_W-1:0]                     o_bres_x1;
  logic [P_Y_COORD_W-1:0]                     o_bres_y0;
  logic [P_Y_COORD_W-1:0]                     o_bres_y1;
  logic                                       o_bres_load;
  logic                                       o_bres_reset;
  logic [P_MAX_LINE_LENGTH*P_X_COORD_W-1:0]   i_bres_x_vals;
  logic [P_MAX_LINE_LENGTH*P_Y_COORD_W-1:0]   i_bres_y_vals;
  logic [P_MAX_LINE_LENGTH-1:0]               i_bres_valid;
  logic                                       i_bres_rdy;
  logic                                       o_pix_valid;
  logic [P_X_COORD_W-1:0]                     o_pix_x;
  logic [P_Y_COORD_W-1:0]                     o_pix_y;
  logic                                       o_pix_last;
  logic [SRC_W-1:0]                           o_pix_src;
  logic                                       i_pix_ready;
  logic                                       o_busy;
  logic                                       o_timeout;

  modport master (
    output i_req_valid, i_req_coords, i_bres_x_vals, i_bres_y_vals,
           i_bres_valid, i_bres_rdy, i_pix_ready,
    input  o_req_ready, o_bres_x0, o_bres_x1, o_bres_y0, o_bres_y1,
           o_bres_load, o_bres_reset, o_pix_valid, o_pix_x, o_pix_y,
           o_pix_last, o_pix_src, o_busy, o_timeout
  );

  modport slave (
    input  i_req_valid, i_req_coords, i_bres_x_vals, i_bres_y_vals,
           i_bres_valid, i_bres_rdy, i_pix_ready,
    output o_req_ready, o_bres_x0, o_bres_x1, o_bres_y0, o_bres_y1,
           o_bres_load, o_bres_reset, o_pix_valid, o_pix_x, o_pix_y,
           o_pix_last, o_pix_src, o_busy, o_timeout
  );

endinterface

// File: rtl/line_draw_sequencer_rr_arbiter.sv
// Combinational round-robin arbiter: grants the first requester at or after
// ptr_i, wrapping to the lowest index.
module rr_arbiter
  import line_draw_sequencer_pkg::*;
#(
  parameter int unsigned P_NUM_REQ = 2,
  localparam int unsigned SRC_W    = idx_width(P_NUM_REQ)
) (
  input  logic [P_NUM_REQ-1:0] req_i,
  input  logic [SRC_W-1:0]     ptr_i,
  output logic [P_NUM_REQ-1:0] grant_o,
  output logic [SRC_W-1:0]     grant_idx_o,
  output logic                 any_o
);

  always_comb begin
    grant_o     = '0;
    grant_idx_o = '0;
    any_o       = 1'b0;
    // First pass covers [ptr, N-1]; second pass wraps to [0, N-1].
    for (int unsigned j = 0; j < P_NUM_REQ; j++) begin
      if (!any_o && req_i[j] && (j >= int'(ptr_i))) begin
        any_o       = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = SRC_W'(j);
      end
    end
    for (int unsigned j = 0; j < P_NUM_REQ; j++) begin
      if (!any_o && req_i[j]) begin
        any_o       = 1'b1;
        grant_o[j]  = 1'b1;
        grant_idx_o = SRC_W'(j);
      end
    end
  end

endmodule

// File: rtl/line_draw_sequencer.sv
// Shares one bresenham core between several line requesters and streams the
// resulting points one per cycle over a valid/ready pixel port.
module line_draw_sequencer
  import line_draw_sequencer_pkg::*;
#(
  parameter int unsigned P_NUM_REQ         = 2,
  parameter int unsigned P_MAX_LINE_LENGTH = 31,
  parameter int unsigned P_X_COORD_W       = 9,
  parameter int unsigned P_Y_COORD_W       = 9,
  parameter int unsigned P_WAIT_MAX        = 1023
) (
  input logic                 i_clk,
  input logic                 i_reset,
  line_draw_sequencer_if.slave bus
);

  localparam int unsigned SRC_W = idx_width(P_NUM_REQ);
  localparam int unsigned IDX_W = idx_width(P_MAX_LINE_LENGTH);
  localparam int unsigned CNT_W = $clog2(P_WAIT_MAX + 1);
  localparam int unsigned XW    = P_X_COORD_W;
  localparam int unsigned YW    = P_Y_COORD_W;
  localparam int unsigned REQ_W = 2 * XW + 2 * YW;

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(P_MAX_LINE_LENGTH - 1);
  localparam logic [CNT_W-1:0] WAIT_MAX  = CNT_W'(P_WAIT_MAX);
  localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(P_WAIT_MAX - 1);
  localparam logic [SRC_W-1:0] SRC_TOP   = SRC_W'(P_NUM_REQ - 1);

  state_e                 state_q, state_d;
  logic [SRC_W-1:0]       ptr_q, ptr_d;
  logic [SRC_W-1:0]       src_q, src_d;
  logic [XW-1:0]          x0_q, x0_d, x1_q, x1_d;
  logic [YW-1:0]          y0_q, y0_d, y1_q, y1_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]       idx_q, idx_d;
  logic [IDX_W-1:0]       last_q, last_d;

  logic [P_MAX_LINE_LENGTH-1:0][XW-1:0] snap_x_q;
  logic [P_MAX_LINE_LENGTH-1:0][YW-1:0] snap_y_q;
  logic [P_MAX_LINE_LENGTH-1:0]         snap_v_q;
  logic                                 snap_en;

  logic [P_NUM_REQ-1:0]   grant;
  logic [SRC_W-1:0]       grant_idx;
  logic                   grant_any;
  logic [REQ_W-1:0]       sel_coords;
  logic [IDX_W-1:0]       hi_idx;
  logic [SRC_W-1:0]       ptr_next;

  logic                   req_ready;
  logic                   bres_load;
  logic                   bres_reset;
  logic                   pix_valid;
  logic                   timeout;

  rr_arbiter #(
    .P_NUM_REQ (P_NUM_REQ)
  ) u_rr_arbiter (
    .req_i       (bus.i_req_valid),
    .ptr_i       (ptr_q),
    .grant_o     (grant),
    .grant_idx_o (grant_idx),
    .any_o       (grant_any)
  );

  always_comb begin
    sel_coords = '0;
    for (int unsigned r = 0; r < P_NUM_REQ; r++) begin
      if (grant[r]) sel_coords = bus.i_req_coords[r*REQ_W +: REQ_W];
    end
  end

  always_comb begin
    hi_idx = '0;
    for (int unsigned i = 0; i < P_MAX_LINE_LENGTH; i++) begin
      if (bus.i_bres_valid[i]) hi_idx = IDX_W'(i);
    end
  end

  assign ptr_next = (src_q == SRC_TOP) ? '0 : src_q + 1'b1;

  always_comb begin
    state_d    = state_q;
    ptr_d      = ptr_q;
    src_d      = src_q;
    x0_d       = x0_q;
    y0_d       = y0_q;
    x1_d       = x1_q;
    y1_d       = y1_q;
    cnt_d      = cnt_q;
    idx_d      = idx_q;
    last_d     = last_q;
    snap_en    = 1'b0;
    req_ready  = 1'b0;
    bres_load  = 1'b0;
    bres_reset = 1'b0;
    pix_valid  = 1'b0;
    timeout    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        // Accept is suppressed during reset so a granted line is never lost.
        if (grant_any && !i_reset) begin
          req_ready = 1'b1;
          src_d     = grant_idx;
          {x0_d, y0_d, x1_d, y1_d} = sel_coords;
          state_d   = ST_LOAD;
        end
      end
      ST_LOAD: begin
        bres_load = 1'b1;
        cnt_d     = '0;
        state_d   = ST_WAIT;
      end
      ST_WAIT: begin
        if (bus.i_bres_rdy) begin
          snap_en = 1'b1;
          idx_d   = '0;
          last_d  = hi_idx;
          state_d = ST_STREAM;
        end else if (cnt_q == WAIT_LAST) begin
          timeout    = 1'b1;
          bres_reset = 1'b1;
          state_d    = ST_IDLE;
        end else if (cnt_q != WAIT_MAX) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_STREAM: begin
        if (snap_v_q[idx_q]) begin
          pix_valid = 1'b1;
          if (bus.i_pix_ready) begin
            if (idx_q == last_q) begin
              ptr_d   = ptr_next;
              state_d = ST_IDLE;
            end else begin
              idx_d = idx_q + 1'b1;
            end
          end
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_IDLE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      src_q    <= '0;
      x0_q     <= '0;
      y0_q     <= '0;
      x1_q     <= '0;
      y1_q     <= '0;
      cnt_q    <= '0;
      idx_q    <= '0;
      last_q   <= '0;
      snap_x_q <= '0;
      snap_y_q <= '0;
      snap_v_q <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      src_q   <= src_d;
      x0_q    <= x0_d;
      y0_q    <= y0_d;
      x1_q    <= x1_d;
      y1_q    <= y1_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      if (snap_en) begin
        snap_x_q <= bus.i_bres_x_vals;
        snap_y_q <= bus.i_bres_y_vals;
        snap_v_q <= bus.i_bres_valid;
      end
    end
  end

  assign bus.o_req_ready  = req_ready ? grant : '0;
  assign bus.o_bres_x0    = x0_q;
  assign bus.o_bres_y0    = y0_q;
  assign bus.o_bres_x1    = x1_q;
  assign bus.o_bres_y1    = y1_q;
  assign bus.o_bres_load  = bres_load;
  assign bus.o_bres_reset = bres_reset;
  assign bus.o_pix_valid  = pix_valid;
  assign bus.o_pix_x      = pix_valid ? snap_x_q[idx_q] : '0;
  assign bus.o_pix_y      = pix_valid ? snap_y_q[idx_q] : '0;
  assign bus.o_pix_last   = pix_valid && (idx_q == last_q);
  assign bus.o_pix_src    = src_q;
  assign bus.o_busy       = (state_q != ST_IDLE);
  assign bus.o_timeout    = timeout;

endmodule

// File: tb/tb_line_draw_sequencer.sv
// Scoreboard bench for line_draw_sequencer with a behavioural bresenham core.
module tb_line_draw_sequencer;

  localparam int unsigned N    = 2;
  localparam int unsigned L    = 31;
  localparam int unsigned XW   = 9;
  localparam int unsigned YW   = 9;
  localparam int unsigned WMAX = 1023;
  localparam int          CORE_LAT = 3;

  typedef struct packed {
    logic [XW-1:0] x0;
    logic [YW-1:0] y0;
    logic [XW-1:0] x1;
    logic [YW-1:0] y1;
  } line_t;

  typedef struct packed {
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic          last;
    logic [0:0]    src;
  } beat_t;

  typedef struct packed {
    logic [L*XW-1:0] xv;
    logic [L*YW-1:0] yv;
    logic [L-1:0]    vv;
  } core_out_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  line_draw_sequencer_if #(
    .P_NUM_REQ(N), .P_MAX_LINE_LENGTH(L), .P_X_COORD_W(XW), .P_Y_COORD_W(YW)
  ) bus ();

  line_draw_sequencer #(
    .P_NUM_REQ(N), .P_MAX_LINE_LENGTH(L), .P_X_COORD_W(XW),
    .P_Y_COORD_W(YW), .P_WAIT_MAX(WMAX)
  ) dut (
    .i_clk   (clk),
    .i_reset (rst),
    .bus     (bus)
  );

  int    checks = 0;
  int    failures = 0;
  int    loads = 0;
  int    beats_seen = 0;
  int    core_mode = 0;   // 0 contiguous, 1 even slots, 2 no valid points, 3 never ready
  int    rdy_mode = 0;    // 0 ready high, 1 toggling
  beat_t sb[$];
  line_t rq0[$];
  line_t rq1[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  // ---------------- behavioural bresenham core ----------------
  function automatic core_out_t gen_line(input int x0, input int y0, input int x1,
                                         input int y1, input int mode);
    core_out_t o;
    int dx, dy, sx, sy, err, e2, x, y, slot;
    o = '0;
    if (mode == 2) return o;
    dx  = (x1 > x0) ? x1 - x0 : x0 - x1;
    dy  = (y1 > y0) ? y0 - y1 : y1 - y0;
    sx  = (x0 < x1) ? 1 : -1;
    sy  = (y0 < y1) ? 1 : -1;
    err = dx + dy;
    x   = x0;
    y   = y0;
    for (int k = 0; k < int'(L); k++) begin
      slot = (mode == 1) ? 2 * k : k;
      if (slot >= int'(L)) break;
      o.xv[slot*XW +: XW] = XW'(x);
      o.yv[slot*YW +: YW] = YW'(y);
      o.vv[slot] = 1'b1;
      if (x == x1 && y == y1) break;
      e2 = 2 * err;
      if (e2 >= dy) begin err += dy; x += sx; end
      if (e2 <= dx) begin err += dx; y += sy; end
    end
    return o;
  endfunction

  core_out_t core_out = '0;
  int        lat_cnt = 0;
  logic      core_busy = 1'b0;

  assign bus.i_bres_x_vals = core_out.xv;
  assign bus.i_bres_y_vals = core_out.yv;
  assign bus.i_bres_valid  = core_out.vv;

  initial bus.i_bres_rdy = 1'b0;

  always @(posedge clk) begin
    if (rst || bus.o_bres_reset) begin
      bus.i_bres_rdy <= 1'b0;
      core_busy      <= 1'b0;
      lat_cnt        <= 0;
    end else if (bus.o_bres_load) begin
      core_out       <= gen_line(int'(bus.o_bres_x0), int'(bus.o_bres_y0),
                                 int'(bus.o_bres_x1), int'(bus.o_bres_y1), core_mode);
      bus.i_bres_rdy <= 1'b0;
      core_busy      <= 1'b1;
      lat_cnt        <= CORE_LAT;
    end else if (core_busy) begin
      if (lat_cnt > 1) lat_cnt <= lat_cnt - 1;
      else begin
        core_busy <= 1'b0;
        if (core_mode != 3) bus.i_bres_rdy <= 1'b1;
      end
    end
  end

  // ---------------- requester driver ----------------
  initial begin
    logic [N-1:0] grabbed;
    line_t        l0, l1;
    bus.i_req_valid  = '0;
    bus.i_req_coords = '0;
    forever begin
      @(negedge clk);
      grabbed = rst ? '0 : bus.o_req_ready;
      if (grabbed != '0) begin
        check("grant_onehot", 64'($onehot(grabbed)), 64'd1);
        check("grant_only_valid", 64'(grabbed & ~bus.i_req_valid), 64'd0);
      end
      @(posedge clk);
      #1;
      if (grabbed[0] && rq0.size() > 0) void'(rq0.pop_front());
      if (grabbed[1] && rq1.size() > 0) void'(rq1.pop_front());
      l0 = (rq0.size() > 0) ? rq0[0] : '0;
      l1 = (rq1.size() > 0) ? rq1[0] : '0;
      bus.i_req_valid  = {rq1.size() != 0, rq0.size() != 0};
      bus.i_req_coords = {l1, l0};
    end
  end

  // ---------------- pixel ready driver ----------------
  initial begin
    bus.i_pix_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      bus.i_pix_ready = (rdy_mode == 1) ? ~bus.i_pix_ready : 1'b1;
    end
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    beat_t cur, prev_beat, exp_b;
    logic  prev_stall;
    prev_stall = 1'b0;
    prev_beat  = '0;
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        cur = {bus.o_pix_x, bus.o_pix_y, bus.o_pix_last, bus.o_pix_src};
        if (prev_stall) begin
          check("stall_hold_valid", 64'(bus.o_pix_valid), 64'd1);
          check("stall_hold_beat", 64'(cur), 64'(prev_beat));
        end
        if (bus.o_pix_valid && bus.i_pix_ready) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_beat actual=%0h required=none", cur);
          end else begin
            exp_b = sb.pop_front();
            check("beat", 64'(cur), 64'(exp_b));
          end
          beats_seen++;
        end
        prev_stall = bus.o_pix_valid && !bus.i_pix_ready;
        prev_beat  = cur;
        if (bus.o_bres_load) loads++;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic push_beat(input int x, input int y, input bit last, input int src);
    beat_t b;
    b.x = XW'(x);
    b.y = YW'(y);
    b.last = last;
    b.src = 1'(src);
    sb.push_back(b);
  endtask

  task automatic push_diag(input int x0, input int y0, input int n, input int src);
    for (int k = 0; k < n; k++) push_beat(x0 + k, y0 + k, k == n - 1, src);
  endtask

  task automatic push_horiz(input int x0, input int y, input int n, input int src);
    for (int k = 0; k < n; k++) push_beat(x0 + k, y, k == n - 1, src);
  endtask

  task automatic issue(input int r, input int x0, input int y0, input int x1, input int y1);
    line_t l;
    l.x0 = XW'(x0);
    l.y0 = YW'(y0);
    l.x1 = XW'(x1);
    l.y1 = YW'(y1);
    if (r == 0) rq0.push_back(l);
    else rq1.push_back(l);
  endtask

  task automatic wait_idle(input string name, input int budget);
    int t = 0;
    do begin
      @(negedge clk);
      #1;
      t++;
    end while ((sb.size() != 0 || bus.o_busy || rq0.size() != 0 || rq1.size() != 0)
               && t < budget);
    check(name, 64'(sb.size() == 0 && !bus.o_busy && rq0.size() == 0 && rq1.size() == 0),
          64'd1);
  endtask

  task automatic check_all_zero(input string name);
    check(name, {1'b0, bus.o_busy, bus.o_pix_valid, bus.o_pix_last, bus.o_pix_x,
                 bus.o_pix_y, bus.o_pix_src, bus.o_req_ready, bus.o_bres_load,
                 bus.o_bres_reset, bus.o_timeout, bus.o_bres_x0, bus.o_bres_y0,
                 bus.o_bres_x1, bus.o_bres_y1}, 64'd0);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1 rst = 1'b1;
    sb.delete();
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int base, t, k, seen;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_all_zero("reset_state");

    // Single diagonal line, ready always high
    loads = 0;
    push_diag(5, 0, 16, 0);
    issue(0, 5, 0, 20, 15);
    wait_idle("single_line_done", 400);
    check("single_line_loads", 64'(loads), 64'd1);

    // Both requesters pending from reset: expect 0,1,0,1
    pulse_reset();
    loads = 0;
    push_diag(5, 0, 16, 0);
    push_horiz(100, 50, 11, 1);
    push_beat(7, 7, 1'b1, 0);
    push_diag(40, 40, 4, 1);
    issue(0, 5, 0, 20, 15);
    issue(0, 7, 7, 7, 7);
    issue(1, 100, 50, 110, 50);
    issue(1, 40, 40, 43, 43);
    wait_idle("rr_alternate_done", 1500);
    check("rr_alternate_loads", 64'(loads), 64'd4);

    // Downstream ready toggling every cycle
    rdy_mode = 1;
    push_horiz(100, 50, 11, 1);
    issue(1, 100, 50, 110, 50);
    wait_idle("toggle_ready_done", 600);
    rdy_mode = 0;

    // Valid points only on even slots, last point in the final slot
    core_mode = 1;
    push_diag(5, 0, 16, 0);
    issue(0, 5, 0, 20, 15);
    wait_idle("sparse_valid_done", 600);

    // No valid point at all: nothing streamed, back to idle
    core_mode = 2;
    loads = 0;
    issue(0, 5, 0, 20, 15);
    wait_idle("empty_line_done", 600);
    check("empty_line_loads", 64'(loads), 64'd1);

    // Core never ready: timeout on the last WAIT cycle
    core_mode = 3;
    issue(1, 100, 50, 110, 50);
    seen = 0;
    t = 0;
    while (!seen && t < 50) begin
      @(negedge clk);
      seen = bus.o_bres_load;
      t++;
    end
    check("timeout_load_seen", 64'(seen), 64'd1);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.o_timeout && k < 1100);
    check("timeout_cycle", 64'(k), 64'(WMAX));
    check("timeout_bres_reset", 64'(bus.o_bres_reset), 64'd1);
    @(negedge clk);
    check("timeout_back_idle", 64'({bus.o_busy, bus.o_timeout, bus.o_bres_reset}), 64'd0);
    core_mode = 0;
    push_beat(7, 7, 1'b1, 0);
    issue(0, 7, 7, 7, 7);
    wait_idle("after_timeout_done", 400);

    // Reset after 5 beats of a long line, then restart (rr pointer back at 0)
    push_diag(0, 200, 31, 0);
    issue(0, 0, 200, 30, 230);
    base = beats_seen;
    t = 0;
    while ((beats_seen - base) < 5 && t < 200) begin
      @(negedge clk);
      #1;
      t++;
    end
    check("abort_five_beats", 64'(beats_seen - base), 64'd5);
    pulse_reset();
    @(negedge clk);
    check_all_zero("abort_outputs_zero");
    push_diag(5, 0, 16, 0);
    push_horiz(100, 50, 11, 1);
    issue(0, 5, 0, 20, 15);
    issue(1, 100, 50, 110, 50);
    wait_idle("restart_done", 800);

    check("final_scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1_000_000;
    failures++;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog expired");
  end

endmodule
